// File: rtl/alarm_trigger.sv
// Alarm trigger: decides when the ring request to the sound block is asserted.
// It compares wall-clock time against the programmed alarm HH:MM:00 and
// sequences ringing, snoozing, manual stop and ring timeout. Once the event is
// over it re-arms as soon as the alarm minute has passed.
module alarm_trigger #(
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 120,
    parameter int MAX_SNOOZE     = 3,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    input  logic [4:0] al_h,
    input  logic [5:0] al_m,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       alarm,
    output logic       snoozing,
    output logic [1:0] snooze_left,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // second of an interval is N-1 and the expiring tick is the N-th one.
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
    localparam logic [1:0]       MAX_U       = 2'(MAX_SNOOZE);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       used;
    logic [1:0]       used_nxt;
    logic             time_match;

    assign time_match = (cur_h == al_h) && (cur_m == al_m);

    // Next-state logic; events are checked in priority order: disable, stop,
    // snooze, counter expiry, then the time match.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        used_nxt  = used;
        if (!alarm_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            used_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // Only a tick landing exactly on :00 fires, so enabling
                    // mid-minute or a tick-less match never rings.
                    if (sec_tick && time_match && (cur_s == 6'd0)) begin
                        state_nxt = RINGING;
                        cnt_nxt   = '0;
                        used_nxt  = '0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else if (snooze_btn && (used < MAX_U)) begin
                        state_nxt = SNOOZE;
                        cnt_nxt   = '0;
                        used_nxt  = used + 2'd1;
                    end else if (sec_tick) begin
                        if (cnt == RING_LAST) begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    // snooze_btn has no meaning while already snoozing.
                    if (stop_btn) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else if (sec_tick) begin
                        if (cnt == SNOOZE_LAST) begin
                            state_nxt = RINGING;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Hold until the alarm minute is over so the same minute
                    // cannot re-trigger; checked every cycle, not per tick.
                    if (!time_match) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            used     <= '0;
            alarm    <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            used     <= used_nxt;
            alarm    <= (state_nxt == RINGING);
            snoozing <= (state_nxt == SNOOZE);
        end
    end

    assign snooze_left = MAX_U - used;
    assign state_o     = state;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences. Expected outputs are queued when a
// vector is driven and compared one cycle later when the DUT registers them.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic [5:0] cur_s;
    logic [4:0] al_h;
    logic [5:0] al_m;
    logic       alarm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic       alarm;
    logic       snoozing;
    logic [1:0] snooze_left;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic       r, e, t;
        int         h, m, s;
        logic       z, p;
        logic       ea, es;
        logic [1:0] el, est;
    } vec_t;

    typedef struct {
        string      nm;
        logic       ea, es;
        logic [1:0] el, est;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    alarm_trigger #(
        .SNOOZE_S      (5),
        .RING_TIMEOUT_S(4),
        .MAX_SNOOZE    (3),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .cur_h      (cur_h),
        .cur_m      (cur_m),
        .cur_s      (cur_s),
        .al_h       (al_h),
        .al_m       (al_m),
        .alarm_en   (alarm_en),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .alarm      (alarm),
        .snoozing   (snoozing),
        .snooze_left(snooze_left),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s %s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    task automatic cyc(input string nm, input logic r, input logic e, input logic t,
                       input int h, input int m, input int s,
                       input logic z, input logic p,
                       input logic ea, input logic es, input int el, input int est);
        exp_t x;
        exp_t got;
        rst        = r;
        alarm_en   = e;
        sec_tick   = t;
        cur_h      = 5'(h);
        cur_m      = 6'(m);
        cur_s      = 6'(s);
        snooze_btn = z;
        stop_btn   = p;
        x.nm  = nm;
        x.ea  = ea;
        x.es  = es;
        x.el  = 2'(el);
        x.est = 2'(est);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty actual=0 required=1", nm);
        end else begin
            got = exp_q.pop_front();
            chk(got.nm, "alarm",       int'(alarm),       int'(got.ea));
            chk(got.nm, "snoozing",    int'(snoozing),    int'(got.es));
            chk(got.nm, "snooze_left", int'(snooze_left), int'(got.el));
            chk(got.nm, "state_o",     int'(state_o),     int'(got.est));
        end
    endtask

    task automatic add(input string nm, input logic r, input logic e, input logic t,
                       input int h, input int m, input int s,
                       input logic z, input logic p,
                       input logic ea, input logic es, input int el, input int est);
        vec_t v;
        v.nm = nm; v.r = r; v.e = e; v.t = t;
        v.h = h; v.m = m; v.s = s; v.z = z; v.p = p;
        v.ea = ea; v.es = es; v.el = 2'(el); v.est = 2'(est);
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; sec_tick = 1'b0; alarm_en = 1'b0;
        snooze_btn = 1'b0; stop_btn = 1'b0;
        cur_h = '0; cur_m = '0; cur_s = '0;
        al_h = 5'd7; al_m = 6'd30;

        //   name            rst en tk  h  m  s  snz stp  al sn left st
        add("reset",          1, 1, 0,  7, 29, 59, 0, 0,  0, 0, 3, 0);
        add("pre_match",      0, 1, 1,  7, 29, 59, 0, 0,  0, 0, 3, 0);
        add("trigger",        0, 1, 1,  7, 30,  0, 0, 0,  1, 0, 3, 1);
        add("stop",           0, 1, 0,  7, 30,  0, 0, 1,  0, 0, 3, 3);
        add("done_hold",      0, 1, 1,  7, 30,  1, 0, 0,  0, 0, 3, 3);
        add("done_exit",      0, 1, 1,  7, 31,  0, 0, 0,  0, 0, 3, 0);
        add("match_no_tick",  0, 1, 0,  7, 30,  0, 0, 0,  0, 0, 3, 0);
        add("disabled_match", 0, 0, 1,  7, 30,  0, 0, 0,  0, 0, 3, 0);
        add("enable_mid",     0, 1, 0,  7, 30,  5, 0, 0,  0, 0, 3, 0);
        add("tick_s_nonzero", 0, 1, 1,  7, 30,  6, 0, 0,  0, 0, 3, 0);
        add("trigger2",       0, 1, 1,  7, 30,  0, 0, 0,  1, 0, 3, 1);
        add("snooze",         0, 1, 0,  7, 30,  0, 1, 0,  0, 1, 2, 2);
        add("snz_tick1",      0, 1, 1,  7, 30,  1, 0, 0,  0, 1, 2, 2);
        add("snz_tick2_btn",  0, 1, 1,  7, 30,  2, 1, 0,  0, 1, 2, 2);
        add("snz_tick3",      0, 1, 1,  7, 30,  3, 0, 0,  0, 1, 2, 2);
        add("snz_tick4",      0, 1, 1,  7, 30,  4, 0, 0,  0, 1, 2, 2);
        add("snz_expire",     0, 1, 1,  7, 30,  5, 0, 0,  1, 0, 2, 1);
        add("stop_and_snz",   0, 1, 0,  7, 30,  5, 1, 1,  0, 0, 2, 3);
        add("done_to_idle",   0, 1, 0,  7, 45,  0, 0, 0,  0, 0, 2, 0);
        add("trigger3",       0, 1, 1,  7, 30,  0, 0, 0,  1, 0, 3, 1);
        add("snooze3",        0, 1, 0,  7, 30,  0, 1, 0,  0, 1, 2, 2);
        add("disable_snz",    0, 0, 0,  7, 30,  1, 0, 0,  0, 0, 3, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].nm, tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].h, tbl[i].m, tbl[i].s,
                tbl[i].z, tbl[i].p, tbl[i].ea, tbl[i].es, int'(tbl[i].el), int'(tbl[i].est));
        end

        // Snooze exhaustion: three full snooze rounds, the fourth press ignored.
        cyc("ex_arm",     0, 1, 0, 7,  0, 0, 0, 0, 0, 0, 3, 0);
        cyc("ex_trigger", 0, 1, 1, 7, 30, 0, 0, 0, 1, 0, 3, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc("ex_snooze", 0, 1, 0, 7, 30, 0, 1, 0, 0, 1, 3 - k, 2);
            for (int j = 1; j <= 4; j++) begin
                cyc("ex_snz_tick", 0, 1, 1, 7, 30 + k, j, 0, 0, 0, 1, 3 - k, 2);
            end
            cyc("ex_re_ring", 0, 1, 1, 7, 30 + k, 5, 0, 0, 1, 0, 3 - k, 1);
        end
        cyc("ex_4th_press", 0, 1, 0, 7, 34, 0, 1, 0, 1, 0, 0, 1);
        cyc("ex_stop",      0, 1, 0, 7, 34, 0, 0, 1, 0, 0, 0, 3);
        cyc("ex_idle",      0, 1, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0);

        // Ring timeout: alarm holds for exactly four ticks, then no re-trigger.
        cyc("to_trigger", 0, 1, 1, 7, 30, 0, 0, 0, 1, 0, 3, 1);
        for (int j = 1; j <= 3; j++) begin
            cyc("to_ringing", 0, 1, 1, 7, 30, j, 0, 0, 1, 0, 3, 1);
        end
        cyc("to_expire", 0, 1, 1, 7, 30, 4, 0, 0, 0, 0, 3, 3);
        cyc("to_no_re1", 0, 1, 1, 7, 30, 5, 0, 0, 0, 0, 3, 3);
        cyc("to_no_re0", 0, 1, 1, 7, 30, 0, 0, 0, 0, 0, 3, 3);

        // Alarm time changed while DONE releases it on the next cycle.
        al_m = 6'd31;
        cyc("done_al_change", 0, 1, 0, 7, 30, 6, 0, 0, 0, 0, 3, 0);
        al_m = 6'd30;

        // Snooze press on the same cycle as the ring expiry tick: button wins.
        cyc("bx_trigger", 0, 1, 1, 7, 30, 0, 0, 0, 1, 0, 3, 1);
        for (int j = 1; j <= 3; j++) begin
            cyc("bx_ringing", 0, 1, 1, 7, 30, j, 0, 0, 1, 0, 3, 1);
        end
        cyc("bx_snz_wins", 0, 1, 1, 7, 30, 4, 1, 0, 0, 1, 2, 2);
        cyc("bx_stop",     0, 1, 0, 7, 30, 4, 0, 1, 0, 0, 2, 3);
        cyc("bx_idle",     0, 1, 0, 8,  0, 0, 0, 0, 0, 0, 2, 0);

        // Alarm time change while ringing is ignored; reset mid-ring clears all.
        cyc("rr_trigger", 0, 1, 1, 7, 30, 0, 0, 0, 1, 0, 3, 1);
        al_m = 6'd45;
        cyc("rr_al_change", 0, 1, 1, 7, 30, 1, 0, 0, 1, 0, 3, 1);
        cyc("rr_reset",     1, 1, 1, 7, 30, 2, 0, 0, 0, 0, 3, 0);
        al_m = 6'd30;
        cyc("rr_next_day",  0, 1, 1, 7, 30, 0, 0, 0, 1, 0, 3, 1);
        for (int j = 1; j <= 3; j++) begin
            cyc("rr_ringing", 0, 1, 1, 7, 30, j, 0, 0, 1, 0, 3, 1);
        end
        cyc("rr_expire", 0, 1, 1, 7, 30, 4, 0, 0, 0, 0, 3, 3);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
